// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : Pipe_Ctrl_PKG
// Brief    : Shared types and control-word helpers for the pipeline hazard
//            controller (FSM states, bundled buffer controls).
// Revision : 1.0 - initial release
// ============================================================================
package Pipe_Ctrl_PKG;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } haz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_bubble;
        logic mem_timeout;
    } pipe_ctrl_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c.pc_en         = 1'b1;
        c.if_id_en      = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_ex_en      = 1'b1;
        c.id_ex_flush   = 1'b0;
        c.ex_mem_en     = 1'b1;
        c.mem_wb_bubble = 1'b0;
        c.mem_timeout   = 1'b0;
        return c;
    endfunction

    // Whole pipe holds while a data access is outstanding; WB gets a bubble.
    function automatic pipe_ctrl_t ctrl_freeze();
        pipe_ctrl_t c;
        c               = ctrl_run();
        c.pc_en         = 1'b0;
        c.if_id_en      = 1'b0;
        c.id_ex_en      = 1'b0;
        c.ex_mem_en     = 1'b0;
        c.mem_wb_bubble = 1'b1;
        return c;
    endfunction

    function automatic pipe_ctrl_t ctrl_kill();
        pipe_ctrl_t c;
        c               = ctrl_freeze();
        c.if_id_flush   = 1'b1;
        c.id_ex_flush   = 1'b1;
        return c;
    endfunction

    // A redirect squashes the ID instruction, so its load-use hazard is moot.
    function automatic pipe_ctrl_t ctrl_hazard(input logic redirect, input logic load_use);
        pipe_ctrl_t c;
        c = ctrl_run();
        if (redirect) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Saturating data-memory wait counter; flags expiry once the count
//            reaches MEM_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_expired;

    assign w_expired = (r_cnt == C_LIMIT);
    assign o_expired = w_expired;

    // Holding at the limit keeps the count from ever passing MEM_TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush controller for the 5-stage pipeline buffers and PC.
//            Optional feature macro: HAZ_PERF_CNT_EN (stall/redirect counters).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import Pipe_Ctrl_PKG::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    haz_state_e r_state;
    haz_state_e w_next;
    pipe_ctrl_t w_ctrl;
    logic       w_load_use;
    logic       w_tmr_clr;
    logic       w_tmr_inc;
    logic       w_tmr_expired;

    assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_tmr_inc),
        .o_expired (w_tmr_expired)
    );

    always_comb begin
        w_ctrl    = ctrl_run();
        w_next    = r_state;
        w_tmr_clr = 1'b0;
        w_tmr_inc = 1'b0;
        case (r_state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    w_ctrl    = ctrl_freeze();
                    w_next    = MEM_WAIT;
                    w_tmr_inc = 1'b1;
                end else begin
                    w_ctrl    = ctrl_hazard(ex_redirect, w_load_use);
                    w_tmr_clr = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Release wins over a timeout landing in the same cycle.
                if (mem_ready) begin
                    w_ctrl    = ctrl_hazard(ex_redirect, w_load_use);
                    w_next    = RUN;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_ctrl    = ctrl_freeze();
                    w_tmr_inc = 1'b1;
                    if (w_tmr_expired) begin
                        w_next = ERROR;
                    end
                end
            end
            ERROR: begin
                w_ctrl = ctrl_kill();
            end
            default: begin
                w_ctrl = ctrl_kill();
                w_next = ERROR;
            end
        endcase
        if (reset) begin
            w_ctrl = ctrl_kill();
        end
        w_ctrl.mem_timeout = (r_state == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    assign pc_en         = w_ctrl.pc_en;
    assign if_id_en      = w_ctrl.if_id_en;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign id_ex_en      = w_ctrl.id_ex_en;
    assign id_ex_flush   = w_ctrl.id_ex_flush;
    assign ex_mem_en     = w_ctrl.ex_mem_en;
    assign mem_wb_bubble = w_ctrl.mem_wb_bubble;
    assign mem_timeout   = w_ctrl.mem_timeout;
    assign state         = r_state;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stalling;
    logic             w_flushing;

    assign w_stalling = !w_ctrl.pc_en && ((r_state == RUN) || (r_state == MEM_WAIT));
    assign w_flushing = ex_redirect && w_ctrl.id_ex_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stalling && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flushing && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire
